dmem_responder: RTL and testbench

Data-memory responder for the memory stage of the combined ARM/RISC-V pipeline. The memory stage acts as initiator: it issues one load or store per transaction over a valid/ready request channel and waits for a one-cycle response pulse. The block serves each transaction from a word-organised, byte-lane-writable array after a programmable fixed latency. It flags out-of-range and empty-byte-enable requests instead of touching the array.

---
 rtl/dmem_pkg.sv | 35 +++
 rtl/dmem_if.sv | 25 ++
 rtl/dmem_array.sv | 24 ++
 rtl/dmem_responder.sv | 101 ++++++++++
 tb/tb_dmem_responder.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the memory-stage data-memory responder.
package dmem_pkg;

  localparam int unsigned LAT_CNT_W = 4;
  localparam int unsigned LANES     = 4;
  localparam int unsigned LANE_W    = 8;
  localparam int unsigned DATA_W    = LANES * LANE_W;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  // Request fields latched on the accepting edge
  typedef struct packed {
    logic              we;
    logic              err;
    logic [LANES-1:0]  be;
    logic [DATA_W-1:0] wdata;
  } req_t;

  // Replace the enabled byte lanes of old_w with those of new_w
  function automatic logic [DATA_W-1:0] lane_merge(input logic [DATA_W-1:0] old_w,
                                                   input logic [DATA_W-1:0] new_w,
                                                   input logic [LANES-1:0]  be);
    logic [DATA_W-1:0] m;
    m = old_w;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (be[i]) m[i*LANE_W +: LANE_W] = new_w[i*LANE_W +: LANE_W];
    end
    return m;
  endfunction

endpackage

// File: rtl/dmem_if.sv
// Request/response channel between the memory stage (master) and the responder (slave).
interface dmem_if;
  import dmem_pkg::*;

  logic                 req_valid;
  logic                 req_ready;
  logic                 req_we;
  logic [31:0]          req_addr;
  logic [DATA_W-1:0]    req_wdata;
  logic [LANES-1:0]     req_be;
  logic                 rsp_valid;
  logic [DATA_W-1:0]    rsp_rdata;
  logic                 rsp_err;
  logic                 busy;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );
endinterface

// File: rtl/dmem_array.sv
// Word-organised storage with a byte-lane write port and a combinational read port.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W = 13
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [LANES-1:0]  be,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= lane_merge(mem[waddr], wdata, be);
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/dmem_responder.sv
// Serialises load/store transactions onto dmem_array with a fixed response latency.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W  = 13,
  parameter int unsigned LATENCY = 2
) (
  input  logic   clk,
  input  logic   rst,
  dmem_if.slave  bus
);

  localparam logic [LAT_CNT_W-1:0] CNT_LOAD =
    LAT_CNT_W'((LATENCY > 1) ? (LATENCY - 2) : 0);

  initial begin
    assert (LATENCY >= 1 && LATENCY <= 15)
      else $fatal(1, "dmem_responder: LATENCY must be in 1..15");
  end

  state_t               state_q, state_d;
  logic [LAT_CNT_W-1:0] cnt_q;
  req_t                 req_q;
  logic [ADDR_W-1:0]    idx_q;
  logic                 started_q;
  logic                 accept;
  logic                 err_c;
  logic                 arr_we;
  logic [DATA_W-1:0]    arr_rdata;
  logic                 unused_addr_lsb;

  assign unused_addr_lsb = ^bus.req_addr[1:0];
  assign accept = bus.req_valid & bus.req_ready;
  assign err_c  = (bus.req_addr[31:ADDR_W+2] != '0) | (bus.req_be == '0);
  // Rejected requests never reach the array
  assign arr_we = (state_q == RESP) & req_q.we & ~req_q.err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Request capture and latency countdown
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      req_q     <= '0;
      idx_q     <= '0;
      started_q <= 1'b0;
    end else begin
      started_q <= 1'b1;
      if (accept) begin
        req_q <= '{we: bus.req_we, err: err_c, be: bus.req_be, wdata: bus.req_wdata};
        idx_q <= bus.req_addr[ADDR_W+1:2];
        cnt_q <= CNT_LOAD;
      end else if (state_q == WAIT && cnt_q != '0) begin
        cnt_q <= cnt_q - LAT_CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = (LATENCY == 1) ? RESP : WAIT;
      WAIT:    if (cnt_q == '0) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    bus.rsp_err   = 1'b0;
    bus.rsp_rdata = '0;
    bus.busy      = 1'b0;
    case (state_q)
      IDLE: bus.req_ready = started_q;
      WAIT: bus.busy      = 1'b1;
      RESP: begin
        bus.busy      = 1'b1;
        bus.rsp_valid = 1'b1;
        bus.rsp_err   = req_q.err;
        bus.rsp_rdata = (req_q.we | req_q.err) ? '0 : arr_rdata;
      end
      default: ;
    endcase
  end

  dmem_array #(.ADDR_W(ADDR_W)) u_array (
    .clk   (clk),
    .we    (arr_we),
    .waddr (idx_q),
    .wdata (req_q.wdata),
    .be    (req_q.be),
    .raddr (idx_q),
    .rdata (arr_rdata)
  );

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder at LATENCY 2, 1 and 15 sharing one clock and reset.
module tb_dmem_responder;
  import dmem_pkg::*;

  localparam int unsigned AW   = 13;
  localparam int          NDUT = 3;

  function automatic int lat_of(input int g);
    return (g == 0) ? 2 : (g == 1) ? 1 : 15;
  endfunction

  typedef struct {
    int          g;
    logic        we;
    int          idx;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        err;
    logic [31:0] rdata;
    int          acc;
  } sb_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  bit   chk_en = 1'b0;
  bit   b2b = 1'b0;

  logic        dv_valid [NDUT];
  logic        dv_we    [NDUT];
  logic [31:0] dv_addr  [NDUT];
  logic [31:0] dv_wdata [NDUT];
  logic [3:0]  dv_be    [NDUT];
  logic        m_ready  [NDUT];
  logic        m_rvalid [NDUT];
  logic        m_err    [NDUT];
  logic        m_busy   [NDUT];
  logic [31:0] m_rdata  [NDUT];

  sb_t         sb[$];
  logic [31:0] mdl [NDUT][2**AW];
  int          last_rsp [NDUT];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    dmem_if u_if ();
    assign u_if.req_valid = dv_valid[g];
    assign u_if.req_we    = dv_we[g];
    assign u_if.req_addr  = dv_addr[g];
    assign u_if.req_wdata = dv_wdata[g];
    assign u_if.req_be    = dv_be[g];
    assign m_ready[g]     = u_if.req_ready;
    assign m_rvalid[g]    = u_if.rsp_valid;
    assign m_err[g]       = u_if.rsp_err;
    assign m_busy[g]      = u_if.busy;
    assign m_rdata[g]     = u_if.rsp_rdata;

    dmem_responder #(.ADDR_W(AW), .LATENCY(lat_of(g))) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (u_if.slave)
    );
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Monitor: pushes on handshake, pops and compares on response; reset flushes everything
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
    end else begin
      for (int g = 0; g < NDUT; g++) begin
        logic bexp;
        sb_t  e;
        if (!b2b) last_rsp[g] = -1;
        bexp = (sb.size() != 0) && (sb[0].g == g);
        if (chk_en) begin
          check("busy", 32'(m_busy[g]), 32'(bexp));
          check("ready", 32'(m_ready[g]), 32'(!bexp));
        end
        if (dv_valid[g] && m_ready[g]) begin
          e.g     = g;
          e.we    = dv_we[g];
          e.idx   = int'(dv_addr[g][AW+1:2]);
          e.wdata = dv_wdata[g];
          e.be    = dv_be[g];
          e.err   = (dv_addr[g][31:AW+2] != '0) || (dv_be[g] == 4'b0000);
          e.rdata = (e.we || e.err) ? 32'h0 : mdl[g][e.idx];
          e.acc   = cyc;
          sb.push_back(e);
        end
        if (m_rvalid[g]) begin
          if (sb.size() == 0 || sb[0].g != g) begin
            check("orphan_rsp", 32'(m_rvalid[g]), 32'h0);
          end else begin
            e = sb.pop_front();
            check("rsp_rdata", m_rdata[g], e.rdata);
            check("rsp_err", 32'(m_err[g]), 32'(e.err));
            check("latency", 32'(cyc - e.acc), 32'(lat_of(g)));
            if (b2b && last_rsp[g] >= 0)
              check("spacing", 32'(cyc - last_rsp[g]), 32'(lat_of(g) + 1));
            last_rsp[g] = cyc;
            if (e.we && !e.err) begin
              for (int b = 0; b < 4; b++)
                if (e.be[b]) mdl[g][e.idx][8*b +: 8] = e.wdata[8*b +: 8];
            end
          end
        end
      end
    end
  end

  // Present a request and return at the negedge where the handshake is seen
  task automatic issue(input int g, input logic we, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [3:0] be);
    bit ok;
    ok = 1'b0;
    @(posedge clk); #1;
    dv_we[g] = we; dv_addr[g] = addr; dv_wdata[g] = wd; dv_be[g] = be;
    dv_valid[g] = 1'b1;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (m_ready[g]) begin ok = 1'b1; break; end
    end
    if (!ok) check("accept_timeout", 32'h0, 32'h1);
  endtask

  task automatic release_req(input int g);
    @(posedge clk); #1;
    dv_valid[g] = 1'b0;
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (sb.size() == 0) begin ok = 1'b1; break; end
    end
    if (!ok) check("drain_timeout", 32'(sb.size()), 32'h0);
    repeat (2) @(negedge clk);
  endtask

  task automatic xact(input int g, input logic we, input logic [31:0] addr,
                      input logic [31:0] wd, input logic [3:0] be);
    issue(g, we, addr, wd, be);
    release_req(g);
    drain();
  endtask

  task automatic check_all_zero(input string tag);
    for (int g = 0; g < NDUT; g++) begin
      check({tag, "_ready"}, 32'(m_ready[g]), 32'h0);
      check({tag, "_rvalid"}, 32'(m_rvalid[g]), 32'h0);
      check({tag, "_busy"}, 32'(m_busy[g]), 32'h0);
      check({tag, "_rdata"}, m_rdata[g], 32'h0);
    end
  endtask

  task automatic check_ready_all(input string tag);
    for (int g = 0; g < NDUT; g++) check(tag, 32'(m_ready[g]), 32'h1);
  endtask

  // Run a held-valid burst so every request is accepted in the first IDLE cycle
  task automatic burst(input int g);
    b2b = 1'b1;
    issue(g, 1'b1, 32'h0000_0100, 32'hA5A5_0001, 4'hF);
    issue(g, 1'b1, 32'h0000_0104, 32'h5A5A_0002, 4'hF);
    issue(g, 1'b0, 32'h0000_0100, 32'h0, 4'hF);
    issue(g, 1'b1, 32'h0000_0100, 32'hFFFF_FFFF, 4'b0100);
    issue(g, 1'b0, 32'h0001_0000, 32'h0, 4'hF);
    issue(g, 1'b0, 32'h0000_0104, 32'h0, 4'hF);
    issue(g, 1'b0, 32'h0000_0100, 32'h0, 4'hF);
    release_req(g);
    drain();
    b2b = 1'b0;
  endtask

  initial begin
    for (int g = 0; g < NDUT; g++) begin
      dv_valid[g] = 1'b0; dv_we[g] = 1'b0; dv_addr[g] = '0;
      dv_wdata[g] = '0;   dv_be[g] = '0;   last_rsp[g] = -1;
    end
    repeat (3) @(posedge clk);
    #1 check_all_zero("in_reset");

    @(posedge clk); #2 rst = 1'b0;
    #1 for (int g = 0; g < NDUT; g++) check("ready_before_edge", 32'(m_ready[g]), 32'h0);
    @(posedge clk); #1 check_ready_all("ready_after_release");
    chk_en = 1'b1;

    // LATENCY=2: full store/load, lane merge, errors
    xact(0, 1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 4'hF);
    xact(0, 1'b0, 32'h0000_0040, 32'h0, 4'hF);
    xact(0, 1'b1, 32'h0000_0044, 32'h1122_3344, 4'hF);
    xact(0, 1'b1, 32'h0000_0044, 32'h0000_AA00, 4'b0010);
    xact(0, 1'b0, 32'h0000_0044, 32'h0, 4'b0000);
    xact(0, 1'b0, 32'h0000_8000, 32'h0, 4'hF);
    xact(0, 1'b1, 32'h0000_0044, 32'hFFFF_FFFF, 4'b0000);
    xact(0, 1'b1, 32'hFFFF_0044, 32'hFFFF_FFFF, 4'hF);
    xact(0, 1'b0, 32'h0000_0044, 32'h0, 4'hF);
    xact(0, 1'b0, 32'h0000_0040, 32'h0, 4'hF);

    // Reset while a store waits: the store must never commit
    xact(0, 1'b1, 32'h0000_0080, 32'h1234_5678, 4'hF);
    issue(0, 1'b1, 32'h0000_0080, 32'h0000_0005, 4'hF);
    release_req(0);
    check("busy_in_wait", 32'(m_busy[0]), 32'h1);
    check("rvalid_in_wait", 32'(m_rvalid[0]), 32'h0);
    chk_en = 1'b0;
    #2 rst = 1'b1;
    #1 check_all_zero("async_reset");
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk); #1 check_ready_all("ready_after_abort");
    chk_en = 1'b1;
    repeat (3) @(negedge clk);
    xact(0, 1'b0, 32'h0000_0080, 32'h0, 4'hF);

    // Back-to-back sweeps at the latency extremes
    burst(1);
    burst(2);

    drain();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

endmodule
